// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, byte-enable
// encodings and the access-legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Legal = known size and naturally aligned for that size.
    function automatic logic access_legal(input logic [3:0] be, input logic [1:0] off);
        logic ok;
        case (be)
            BE_BYTE: ok = 1'b1;
            BE_HALF: ok = ~off[0];
            BE_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port of the load/store unit: req/gnt request phase plus rvalid response.
interface lsu_dmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a returned word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  be_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    // Mask to the access size and fill the upper bits.
    always_comb begin
        data_o = shifted;
        case (be_i)
            BE_BYTE: data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            BE_HALF: data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            BE_WORD: data_o = shifted;
            default: data_o = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one aligned, lane-shifted access at a time on a
// req/gnt/rvalid port, with extended load return and pipeline stall.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  mem_wr_en_i,
    input  logic [3:0]            byte_en_i,
    input  logic                  signed_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [4:0]            rd_addr_i,
    output logic                  stall_o,
    output logic                  rdata_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [4:0]            rd_addr_o,
    output logic                  err_o,
    lsu_dmem_if.master            dmem
);
    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d, size_q, size_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d, signed_q, signed_d;
    logic [1:0]            off_q, off_d;
    logic [4:0]            rd_pend_q, rd_pend_d, rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d, err_q, err_d;
    logic [31:0]           ext_data;

    load_extend u_load_extend (
        .rdata_i  (dmem.rdata),
        .offset_i (off_q),
        .be_i     (size_q),
        .signed_i (signed_q),
        .data_o   (ext_data)
    );

    // Next-state and capture logic for the access FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        signed_d  = signed_q;
        off_d     = off_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (!access_legal(byte_en_i, addr_i[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d    = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        be_d      = byte_en_i << addr_i[1:0];
                        size_d    = byte_en_i;
                        wdata_d   = wdata_i << {addr_i[1:0], 3'b000};
                        we_d      = mem_wr_en_i;
                        signed_d  = signed_i;
                        off_d     = addr_i[1:0];
                        rd_pend_d = rd_addr_i;
                        state_d   = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem.gnt) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                // A response arriving on the timeout cycle still completes the load.
                if (dmem.rvalid) begin
                    rdata_d   = ext_data;
                    rd_addr_d = rd_pend_q;
                    rvalid_d  = 1'b1;
                    state_d   = IDLE;
                end else if ((WAIT_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            size_q    <= 4'b0000;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            off_q     <= 2'b00;
            rd_pend_q <= 5'd0;
            rd_addr_q <= 5'd0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            signed_q  <= signed_d;
            off_q     <= off_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign stall_o       = (state_q != IDLE);
    assign rdata_valid_o = rvalid_q;
    assign rdata_o       = rdata_q;
    assign rd_addr_o     = rd_addr_q;
    assign err_o         = err_q;
    assign dmem.req      = (state_q == REQ);
    assign dmem.we       = we_q;
    assign dmem.addr     = addr_q;
    assign dmem.be       = be_q;
    assign dmem.wdata    = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: stores, signed/unsigned loads, alignment
// errors, grant stall, wait timeout and asynchronous reset mid-access.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_wr_en = 1'b0;
    logic [3:0]  byte_en = 4'b0000;
    logic        sgn = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [4:0]  rd = 5'd0;
    logic        stall, rdata_valid, err;
    logic [31:0] rdata;
    logic [4:0]  rd_addr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb[$];

    lsu_dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_bus ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .mem_wr_en_i   (mem_wr_en),
        .byte_en_i     (byte_en),
        .signed_i      (sgn),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rd_addr_i     (rd),
        .stall_o       (stall),
        .rdata_valid_o (rdata_valid),
        .rdata_o       (rdata),
        .rd_addr_o     (rd_addr),
        .err_o         (err),
        .dmem          (dmem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every load completion is matched against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && rdata_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdata_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", rdata, e.data);
                chk("rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
            end
        end
    end

    task automatic bus_chk(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                           input logic [31:0] ewd, input logic ewe);
        chk({tag, "_req"}, {31'd0, dmem_bus.req}, 32'd1);
        chk({tag, "_addr"}, dmem_bus.addr, ea);
        chk({tag, "_be"}, {28'd0, dmem_bus.be}, {28'd0, ebe});
        chk({tag, "_wdata"}, dmem_bus.wdata, ewd);
        chk({tag, "_we"}, {31'd0, dmem_bus.we}, {31'd0, ewe});
        chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
    endtask

    // Issue one request, hold gnt low for gwait cycles, then grant.
    task automatic access(input string tag, input logic we, input logic [3:0] be, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                          input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                          input int gwait);
        @(negedge clk);
        req_valid = 1'b1; mem_wr_en = we; byte_en = be; sgn = s; addr = a; wdata = wd; rd = r;
        @(negedge clk);
        req_valid = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A; byte_en = 4'b0000;
        bus_chk(tag, ea, ebe, ewd, we);
        for (int i = 0; i < gwait; i++) begin
            @(negedge clk);
            bus_chk({tag, "_hold"}, ea, ebe, ewd, we);
        end
        dmem_bus.gnt = 1'b1;
        @(negedge clk);
        dmem_bus.gnt = 1'b0;
        chk({tag, "_req_drop"}, {31'd0, dmem_bus.req}, 32'd0);
    endtask

    task automatic respond(input string tag, input logic [31:0] word, input logic [31:0] ed,
                           input logic [4:0] r);
        exp_t e;
        e.data = ed; e.rd = r;
        sb.push_back(e);
        dmem_bus.rvalid = 1'b1; dmem_bus.rdata = word;
        @(negedge clk);
        dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        chk({tag, "_valid"}, {31'd0, rdata_valid}, 32'd1);
        chk({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic bad_req(input string tag, input logic [3:0] be, input logic [31:0] a);
        @(negedge clk);
        req_valid = 1'b1; mem_wr_en = 1'b0; byte_en = be; sgn = 1'b0; addr = a; rd = 5'd1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_noreq"}, {31'd0, dmem_bus.req}, 32'd0);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_err_pulse"}, {31'd0, err}, 32'd0);
        chk({tag, "_noreq2"}, {31'd0, dmem_bus.req}, 32'd0);
    endtask

    initial begin
        int n;
        logic got;
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_bus.req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stores: byte into lane 3, half into upper lanes.
        access("sb", 1'b1, 4'b0001, 1'b0, 32'h1003, 32'h0000_00AB, 5'd0, 32'h1000, 4'b1000, 32'hAB00_0000, 0);
        chk("sb_idle", {31'd0, stall}, 32'd0);
        access("sh", 1'b1, 4'b0011, 1'b0, 32'h1002, 32'h0000_1234, 5'd0, 32'h1000, 4'b1100, 32'h1234_0000, 1);
        @(negedge clk);
        chk("st_no_rvalid", {31'd0, rdata_valid}, 32'd0);

        // Loads: byte and half, signed and unsigned, plus a word.
        access("lb", 1'b0, 4'b0001, 1'b1, 32'h2001, 32'h0, 5'd7, 32'h2000, 4'b0010, 32'h0, 0);
        respond("lb", 32'h0000_8000, 32'hFFFF_FF80, 5'd7);
        access("lbu", 1'b0, 4'b0001, 1'b0, 32'h2001, 32'h0, 5'd8, 32'h2000, 4'b0010, 32'h0, 0);
        respond("lbu", 32'h0000_8000, 32'h0000_0080, 5'd8);
        access("lh", 1'b0, 4'b0011, 1'b1, 32'h2002, 32'h0, 5'd9, 32'h2000, 4'b1100, 32'h0, 0);
        respond("lh", 32'h8001_1234, 32'hFFFF_8001, 5'd9);
        access("lhu", 1'b0, 4'b0011, 1'b0, 32'h2002, 32'h0, 5'd10, 32'h2000, 4'b1100, 32'h0, 0);
        respond("lhu", 32'h8001_1234, 32'h0000_8001, 5'd10);
        access("lw", 1'b0, 4'b1111, 1'b1, 32'h300C, 32'h0, 5'd31, 32'h300C, 4'b1111, 32'h0, 2);
        @(negedge clk);
        respond("lw", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd31);

        // Load results persist across a store.
        access("sw", 1'b1, 4'b1111, 1'b0, 32'h4000, 32'h1111_2222, 5'd0, 32'h4000, 4'b1111, 32'h1111_2222, 0);
        chk("hold_rdata", rdata, 32'hDEAD_BEEF);
        chk("hold_rd", {27'd0, rd_addr}, 32'd31);

        // Illegal accesses never reach memory.
        bad_req("lw_mis", 4'b1111, 32'h2002);
        bad_req("lh_mis", 4'b0011, 32'h2001);
        bad_req("be_bad", 4'b0101, 32'h2000);

        // Response while idle is ignored.
        dmem_bus.rvalid = 1'b1;
        @(negedge clk);
        dmem_bus.rvalid = 1'b0;
        @(negedge clk);
        chk("idle_rvalid", {31'd0, rdata_valid}, 32'd0);

        // Grant stall followed by a missing response: timeout after 4 WAIT cycles.
        access("to", 1'b0, 4'b1111, 1'b0, 32'h5000, 32'h0, 5'd3, 32'h5000, 4'b1111, 32'h0, 3);
        n = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (err) begin got = 1'b1; break; end
            if (stall && !dmem_bus.req) n++;
            @(negedge clk);
        end
        chk("to_err", {31'd0, got}, 32'd1);
        chk("to_wait_cycles", n, 32'd4);
        chk("to_idle", {31'd0, stall}, 32'd0);
        chk("to_no_rvalid", {31'd0, rdata_valid}, 32'd0);

        // Response on the timeout cycle completes the load instead of erroring.
        access("tw", 1'b0, 4'b0001, 1'b0, 32'h5003, 32'h0, 5'd4, 32'h5000, 4'b1000, 32'h0, 0);
        repeat (3) @(negedge clk);
        respond("tw", 32'h7F00_0000, 32'h0000_007F, 5'd4);
        chk("tw_no_err", {31'd0, err}, 32'd0);

        // Reset while requesting, then while waiting.
        @(negedge clk);
        req_valid = 1'b1; mem_wr_en = 1'b0; byte_en = 4'b1111; addr = 32'h6000; rd = 5'd5;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_req_drop", {31'd0, dmem_bus.req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access("rw", 1'b0, 4'b1111, 1'b0, 32'h6000, 32'h0, 5'd6, 32'h6000, 4'b1111, 32'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_stall", {31'd0, stall}, 32'd0);
        chk("rw_ready", {31'd0, req_ready}, 32'd1);
        chk("rw_rdata", rdata, 32'd0);
        chk("rw_rd", {27'd0, rd_addr}, 32'd0);
        chk("rw_addr", dmem_bus.addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_bus.rvalid = 1'b0;
        chk("rw_ignored", {31'd0, rdata_valid}, 32'd0);
        @(negedge clk);
        chk("rw_no_err", {31'd0, err}, 32'd0);
        chk("rw_no_valid", {31'd0, rdata_valid}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
